// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a small input FIFO.
//   Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1),
//   each bit held for CLKS_PER_BIT cycles. Frames stream back-to-back while the
//   FIFO holds words.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_tx_valid/i_tx_data upstream word offer (accepted when o_tx_ready)
//   o_tx_ready           FIFO not full (registered count only)
//   o_tx_serial          registered serial line, idle high
//   o_tx_busy            frame in progress or FIFO non-empty
//   o_fifo_count         FIFO occupancy
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tx_valid,
    input  logic [DATA_BITS-1:0]          i_tx_data,
    output logic                          o_tx_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("uart_tx_frame: illegal parameter value");
    end

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   ser_q, ser_d;
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic                   push, pop, tick, load;
    logic [DATA_BITS-1:0]   head;

    assign head        = mem[rptr_q];
    assign push        = i_tx_valid && o_tx_ready;
    assign tick        = (clk_cnt_q == CLK_LAST);
    assign o_tx_ready  = (count_q != DEPTH_C);
    assign o_tx_busy   = (state_q != S_IDLE) || (count_q != '0);
    assign o_tx_serial = ser_q;
    assign o_fifo_count = count_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = tick ? '0 : clk_cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ser_d     = ser_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ser_d     = 1'b1;
                clk_cnt_d = '0;
                load      = (count_q != '0);
            end
            S_START: if (tick) begin
                state_d = S_DATA;
                ser_d   = shift_q[0];
            end
            S_DATA: if (tick) begin
                if (bit_q == DATA_LAST) begin
                    bit_d = '0;
                    if (PARITY != 0) begin
                        state_d = S_PARITY;
                        ser_d   = par_q;
                    end else begin
                        state_d = S_STOP;
                        ser_d   = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = shift_q >> 1;
                    ser_d   = shift_q[1];
                end
            end
            S_PARITY: if (tick) begin
                state_d = S_STOP;
                ser_d   = 1'b1;
                bit_d   = '0;
            end
            S_STOP: if (tick) begin
                if (bit_q == STOP_LAST) begin
                    // Pop straight into the next start bit: no idle gap.
                    load    = (count_q != '0);
                    state_d = S_IDLE;
                    ser_d   = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                ser_d     = 1'b1;
                clk_cnt_d = '0;
            end
        endcase
        pop = load;
        if (load) begin
            state_d   = S_START;
            shift_d   = head;
            par_d     = (^head) ^ ODD;
            ser_d     = 1'b0;
            bit_d     = '0;
            clk_cnt_d = '0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ser_q     <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ser_q     <= ser_d;
            count_q   <= count_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) mem[wptr_q] <= i_tx_data;
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0;
    logic [8:0] d = '0;
    logic [1:0] sel = 2'd0;
    int         nchk = 0;
    int         nerr = 0;

    logic [3:0] rdy, ser, busy;
    logic [2:0] cnt [4];
    logic       s_ser, s_rdy, s_busy;
    logic [2:0] s_cnt;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 7E2, 2: 7O2, 3: 9N1 -- all CLKS_PER_BIT = 4, depth 4
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(v && sel == 2'd0), .i_tx_data(d[7:0]),
        .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]), .o_tx_busy(busy[0]), .o_fifo_count(cnt[0]));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(v && sel == 2'd1), .i_tx_data(d[6:0]),
        .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]), .o_tx_busy(busy[1]), .o_fifo_count(cnt[1]));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(v && sel == 2'd2), .i_tx_data(d[6:0]),
        .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]), .o_tx_busy(busy[2]), .o_fifo_count(cnt[2]));
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_9n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(v && sel == 2'd3), .i_tx_data(d),
        .o_tx_ready(rdy[3]), .o_tx_serial(ser[3]), .o_tx_busy(busy[3]), .o_fifo_count(cnt[3]));

    assign s_ser  = ser[sel];
    assign s_rdy  = rdy[sel];
    assign s_busy = busy[sel];
    assign s_cnt  = cnt[sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one whole frame cycle by cycle against bench-built bit list.
    // gapfree: the start bit must already be on the line at entry.
    task automatic run_frame(input logic [8:0] w, input int nb, input int pm, input int sb,
                             input bit gapfree, input string tag);
        logic [15:0] bits;
        logic        p;
        int          len;
        int          t;
        bits    = '1;
        bits[0] = 1'b0;
        p       = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bits[1+i] = w[i];
            p = p ^ w[i];
        end
        if (pm == 2) p = ~p;
        if (pm != 0) bits[1+nb] = p;
        len = 1 + nb + (pm != 0 ? 1 : 0) + sb;
        if (gapfree) begin
            chk({tag, "_gap"}, s_ser, 0);
        end else begin
            t = 0;
            while (s_ser !== 1'b0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                chk({tag, "_start_timeout"}, 1, 0);
                return;
            end
        end
        for (int i = 0; i < len * 4; i++) begin
            chk($sformatf("%s_w%0h_bit%0d", tag, w, i / 4), s_ser, bits[i/4]);
            @(negedge clk);
        end
    endtask

    // Queue three words: first pops at edge 2, two stay queued.
    task automatic push3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        @(negedge clk); v = 1'b1; d = a;
        @(negedge clk); d = b;
        @(negedge clk); d = c;
        @(negedge clk); v = 1'b0;
    endtask

    initial begin
        // reset state
        sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_ser", s_ser, 1);
        chk("rst_rdy", s_rdy, 1);
        chk("rst_busy", s_busy, 0);
        chk("rst_cnt", s_cnt, 0);
        rst_n = 1'b1;

        // 8N1 single word, pushed on first edge after release
        v = 1'b1; d = 9'h0A5;
        @(negedge clk); v = 1'b0;
        chk("lat_cnt", s_cnt, 1);
        chk("lat_ser", s_ser, 1);
        chk("lat_busy", s_busy, 1);
        @(negedge clk);
        chk("lat_cnt_pop", s_cnt, 0);
        run_frame(9'h0A5, 8, 0, 1, 1'b1, "8n1");
        chk("8n1_busy_end", s_busy, 0);
        chk("8n1_ser_end", s_ser, 1);

        // 7E2 / 7O2 with 0x53
        sel = 2'd1;
        @(negedge clk); v = 1'b1; d = 9'h053;
        @(negedge clk); v = 1'b0;
        run_frame(9'h053, 7, 1, 2, 1'b0, "7e2");
        chk("7e2_busy_end", s_busy, 0);
        sel = 2'd2;
        @(negedge clk); v = 1'b1; d = 9'h053;
        @(negedge clk); v = 1'b0;
        run_frame(9'h053, 7, 2, 2, 1'b0, "7o2");
        chk("7o2_busy_end", s_busy, 0);

        // FIFO fill and stream 0x01..0x06
        sel = 2'd0;
        fork
            begin
                int idx = 1;
                int t = 0;
                while (idx <= 6 && t < 2000) begin
                    @(negedge clk);
                    d = 9'(idx); v = 1'b1;
                    if (s_rdy) idx++;
                    t++;
                end
                @(negedge clk); v = 1'b0;
                if (t >= 2000) chk("fill_timeout", 1, 0);
            end
            begin
                repeat (8) @(negedge clk);
                chk("fill_cnt", s_cnt, 4);
                chk("fill_rdy", s_rdy, 0);
            end
            begin
                for (int k = 1; k <= 6; k++)
                    run_frame(9'(k), 8, 0, 1, k > 1, "fifo");
                chk("fifo_busy_end", s_busy, 0);
            end
        join

        // push coincident with STOP->START pop at count 2
        fork
            begin
                push3(9'h011, 9'h022, 9'h033);
                repeat (38) @(negedge clk);
                v = 1'b1; d = 9'h044;
                @(negedge clk); v = 1'b0;
                chk("pp_cnt", s_cnt, 2);
            end
            begin
                run_frame(9'h011, 8, 0, 1, 1'b0, "pp");
                run_frame(9'h022, 8, 0, 1, 1'b1, "pp");
                run_frame(9'h033, 8, 0, 1, 1'b1, "pp");
                run_frame(9'h044, 8, 0, 1, 1'b1, "pp");
                chk("pp_busy_end", s_busy, 0);
            end
        join

        // 9N1 all ones
        sel = 2'd3;
        @(negedge clk); v = 1'b1; d = 9'h1FF;
        @(negedge clk); v = 1'b0;
        run_frame(9'h1FF, 9, 0, 1, 1'b0, "9n1");
        chk("9n1_busy_end", s_busy, 0);

        // reset during data bit 3 with two words queued
        sel = 2'd0;
        push3(9'h05A, 9'h0C3, 9'h081);
        repeat (16) @(negedge clk);
        chk("mid_busy_pre", s_busy, 1);
        chk("mid_cnt_pre", s_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_ser", s_ser, 1);
        chk("mid_cnt", s_cnt, 0);
        chk("mid_busy", s_busy, 0);
        chk("mid_rdy", s_rdy, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            logic low = 1'b0;
            repeat (120) begin
                @(negedge clk);
                if (s_ser !== 1'b1) low = 1'b1;
            end
            chk("mid_no_stale", low, 0);
            chk("mid_busy_after", s_busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
